// File: rtl/instr_feeder_pkg.sv
// ----------------------------------------------------------------------------
// instr_feeder_pkg
// Shared definitions for the instruction feeder: FSM state encoding, default
// parameter values and a small width helper.
// Optional feature macro used by this codebase slice: INSTR_FEEDER_LOOP_EN
// ----------------------------------------------------------------------------
package instr_feeder_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_HOLD_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width that never collapses to zero bits (HOLD_CYCLES may be 1).
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// ----------------------------------------------------------------------------
// instr_feeder_if
// Bundles the load port, playback controls and processor-facing outputs of
// instr_feeder.
//   master : the program source / controller (drives load, start, clear)
//   slave  : the feeder itself (drives load_ready, iin, proc_resetn, status)
// Signals: load_valid, load_data[WIDTH], load_ready, start, clear,
//          iin[WIDTH], proc_resetn, busy, done, count[$clog2(DEPTH)+1],
//          loop (only when INSTR_FEEDER_LOOP_EN is defined)
// ----------------------------------------------------------------------------
interface instr_feeder_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             start;
    logic             clear;
    logic [WIDTH-1:0] iin;
    logic             proc_resetn;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
`ifdef INSTR_FEEDER_LOOP_EN
    logic             loop;

    modport master (
        output load_valid, load_data, start, clear, loop,
        input  load_ready, iin, proc_resetn, busy, done, count
    );
    modport slave (
        input  load_valid, load_data, start, clear, loop,
        output load_ready, iin, proc_resetn, busy, done, count
    );
`else
    modport master (
        output load_valid, load_data, start, clear,
        input  load_ready, iin, proc_resetn, busy, done, count
    );
    modport slave (
        input  load_valid, load_data, start, clear,
        output load_ready, iin, proc_resetn, busy, done, count
    );
`endif

endinterface

// File: rtl/instr_feeder_mem.sv
// ----------------------------------------------------------------------------
// feeder_mem
// DEPTH x WIDTH program store: one synchronous write port, one asynchronous
// read port.
//   clock        : write clock
//   we/waddr/wdata : write port, captured on the rising edge
//   raddr/rdata  : combinational read port
// ----------------------------------------------------------------------------
module feeder_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; contents are only read at
    // addresses below count, which the top clears on reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_feeder.sv
// ----------------------------------------------------------------------------
// instr_feeder
// Buffers a short program through a load port and, on start, plays it onto
// the processor's iin input, holding each instruction for HOLD_CYCLES cycles.
// Also generates the processor's active-low reset (held low while IDLE).
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : instr_feeder_if.slave (load port, start/clear, iin, proc_resetn,
//           busy, done, count; plus loop with INSTR_FEEDER_LOOP_EN)
// Optional feature: define INSTR_FEEDER_LOOP_EN to add the loop input, which
// wraps playback back to address 0 instead of finishing.
// All outputs are registers; nothing combinational reaches an output.
// ----------------------------------------------------------------------------
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input logic            clock,
    input logic            reset,
    instr_feeder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = clog2_min1(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [AW-1:0]    rd_addr;
    logic [HW-1:0]    hold;
    logic [WIDTH-1:0] iin_r;
    logic             proc_resetn_r;
    logic             busy_r;
    logic             done_r;
    logic             load_ready_r;

    logic             load_fire;
    logic             advance;
    logic             last;
    logic             loop_en;
    logic [AW-1:0]    rd_sel;
    logic [WIDTH-1:0] rd_data;

`ifdef INSTR_FEEDER_LOOP_EN
    assign loop_en = bus.loop;
`else
    assign loop_en = 1'b0;
`endif

    // load_ready is only ever high in IDLE with room left.
    assign load_fire = bus.load_valid && load_ready_r;
    assign advance   = (state == PLAY) && (hold == HOLD_MAX);
    assign last      = ({1'b0, rd_addr} == (count - 1'b1));

    // The read port looks one step ahead so iin can be registered: the next
    // address while advancing mid-program, otherwise address 0 (start,
    // replay or loop wrap).
    // NOTE: rd_sel gets a value on every path so no latch is inferred.
    always_comb begin
        rd_sel = '0;
        if (advance && !last) begin
            rd_sel = rd_addr + 1'b1;
        end
    end

    feeder_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (load_fire && !bus.clear),
        .waddr (count[AW-1:0]),
        .wdata (bus.load_data),
        .raddr (rd_sel),
        .rdata (rd_data)
    );

    // NOTE: all state and outputs update with non-blocking assignments so
    // every branch reads the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            rd_addr       <= '0;
            hold          <= '0;
            iin_r         <= '0;
            proc_resetn_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            load_ready_r  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.clear) begin
                        // clear beats both a same-cycle load and start
                        count        <= '0;
                        load_ready_r <= 1'b1;
                    end else begin
                        if (load_fire) begin
                            count        <= count + 1'b1;
                            load_ready_r <= ((count + 1'b1) < DEPTH_CNT);
                        end
                        if (bus.start && (count != '0)) begin
                            state         <= PLAY;
                            rd_addr       <= '0;
                            hold          <= '0;
                            iin_r         <= rd_data;
                            proc_resetn_r <= 1'b1;
                            busy_r        <= 1'b1;
                            load_ready_r  <= 1'b0;
                        end
                    end
                end

                PLAY: begin
                    if (advance) begin
                        hold <= '0;
                        if (last && !loop_en) begin
                            state  <= DONE;
                            iin_r  <= '0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            // rd_sel already holds rd_addr+1 or the wrap to 0
                            rd_addr <= rd_sel;
                            iin_r   <= rd_data;
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end

                DONE: begin
                    if (bus.clear) begin
                        state         <= IDLE;
                        count         <= '0;
                        proc_resetn_r <= 1'b0;
                        done_r        <= 1'b0;
                        load_ready_r  <= 1'b1;
                    end else if (bus.start) begin
                        state   <= PLAY;
                        rd_addr <= '0;
                        hold    <= '0;
                        iin_r   <= rd_data;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.iin         = iin_r;
    assign bus.proc_resetn = proc_resetn_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.count       = count;
    assign bus.load_ready  = load_ready_r;

endmodule

// File: tb/tb_instr_feeder.sv
// ----------------------------------------------------------------------------
// tb_instr_feeder
// Directed bench for instr_feeder with WIDTH=16, DEPTH=4, HOLD_CYCLES=4.
// Inputs are driven and outputs sampled on the falling edge of clock; the
// design acts on the rising edge in between. "Cycle c" is the c-th falling
// edge after the rising edge that sampled start.
// ----------------------------------------------------------------------------
module tb_instr_feeder;

    localparam int W = 16;
    localparam int D = 4;
    localparam int H = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] prog [4] = '{16'hA01C, 16'hA40A, 16'h2080, 16'h8000};

    instr_feeder_if #(.WIDTH(W), .DEPTH(D)) fbus ();

    instr_feeder #(
        .WIDTH       (W),
        .DEPTH       (D),
        .HOLD_CYCLES (H)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (fbus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load_word(input logic [15:0] d);
        fbus.load_valid = 1'b1;
        fbus.load_data  = d;
        cyc(1);
        fbus.load_valid = 1'b0;
    endtask

    // Returns at cycle 1 after the start edge.
    task automatic pulse_start();
        fbus.start = 1'b1;
        cyc(1);
        fbus.start = 1'b0;
    endtask

    initial begin
        fbus.load_valid = 1'b0;
        fbus.load_data  = '0;
        fbus.start      = 1'b0;
        fbus.clear      = 1'b0;
`ifdef INSTR_FEEDER_LOOP_EN
        fbus.loop       = 1'b0;
`endif

        // Reset held for two cycles
        reset = 1'b1;
        cyc(2);
        check("rst_iin",         32'(fbus.iin),         32'h0);
        check("rst_proc_resetn", 32'(fbus.proc_resetn), 32'h0);
        check("rst_count",       32'(fbus.count),       32'h0);
        check("rst_load_ready",  32'(fbus.load_ready),  32'h1);
        check("rst_busy",        32'(fbus.busy),        32'h0);
        check("rst_done",        32'(fbus.done),        32'h0);
        reset = 1'b0;

        // start with an empty buffer is ignored
        pulse_start();
        check("empty_start_busy",        32'(fbus.busy),        32'h0);
        check("empty_start_iin",         32'(fbus.iin),         32'h0);
        check("empty_start_proc_resetn", 32'(fbus.proc_resetn), 32'h0);

        // Fill the 4-entry buffer, then offer a 5th word that must be dropped
        for (int i = 0; i < 4; i++) begin
            load_word(prog[i]);
        end
        check("full_count",      32'(fbus.count),      32'h4);
        check("full_load_ready", 32'(fbus.load_ready), 32'h0);
        load_word(16'hDEAD);
        check("full_5th_count",  32'(fbus.count),      32'h4);

        // Playback: each word for 4 cycles, done at cycle 17
        pulse_start();
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) cyc(1);
            check($sformatf("play_iin_c%0d", c), 32'(fbus.iin), 32'(prog[(c - 1) / 4]));
            check($sformatf("play_busy_c%0d", c), 32'(fbus.busy), 32'h1);
            check($sformatf("play_prn_c%0d", c), 32'(fbus.proc_resetn), 32'h1);
            check($sformatf("play_done_c%0d", c), 32'(fbus.done), 32'h0);
        end
        cyc(1);
        check("c17_done",        32'(fbus.done),        32'h1);
        check("c17_iin",         32'(fbus.iin),         32'h0);
        check("c17_busy",        32'(fbus.busy),        32'h0);
        check("c17_proc_resetn", 32'(fbus.proc_resetn), 32'h1);
        cyc(1);
        check("c18_iin",  32'(fbus.iin),  32'h0);
        check("c18_done", 32'(fbus.done), 32'h1);

        // Replay from DONE, then reset during the 2nd instruction
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) cyc(1);
            check($sformatf("replay_iin_c%0d", c), 32'(fbus.iin), 32'(prog[(c - 1) / 4]));
        end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midrst_busy",        32'(fbus.busy),        32'h0);
        check("midrst_iin",         32'(fbus.iin),         32'h0);
        check("midrst_proc_resetn", 32'(fbus.proc_resetn), 32'h0);
        check("midrst_count",       32'(fbus.count),       32'h0);
        check("midrst_load_ready",  32'(fbus.load_ready),  32'h1);

        // clear and load in the same cycle: clear wins
        load_word(16'h1111);
        check("pre_clear_count", 32'(fbus.count), 32'h1);
        fbus.clear      = 1'b1;
        fbus.load_valid = 1'b1;
        fbus.load_data  = 16'h2222;
        cyc(1);
        fbus.clear      = 1'b0;
        fbus.load_valid = 1'b0;
        check("clear_load_count",      32'(fbus.count),      32'h0);
        check("clear_load_load_ready", 32'(fbus.load_ready), 32'h1);

        // Single-word program, then clear out of DONE
        load_word(16'h3333);
        pulse_start();
        check("one_c1_iin", 32'(fbus.iin), 32'h3333);
        cyc(3);
        check("one_c4_iin", 32'(fbus.iin), 32'h3333);
        cyc(1);
        check("one_c5_done", 32'(fbus.done), 32'h1);
        check("one_c5_iin",  32'(fbus.iin),  32'h0);
        fbus.clear = 1'b1;
        cyc(1);
        fbus.clear = 1'b0;
        check("done_clear_done",        32'(fbus.done),        32'h0);
        check("done_clear_proc_resetn", 32'(fbus.proc_resetn), 32'h0);
        check("done_clear_count",       32'(fbus.count),       32'h0);
        check("done_clear_load_ready",  32'(fbus.load_ready),  32'h1);

`ifdef INSTR_FEEDER_LOOP_EN
        // Looping: 0x8000 is followed by 0xA01C with done low
        for (int i = 0; i < 4; i++) begin
            load_word(prog[i]);
        end
        fbus.loop = 1'b1;
        pulse_start();
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) cyc(1);
            check($sformatf("loop_iin_c%0d", c), 32'(fbus.iin), 32'(prog[((c - 1) / 4) % 4]));
            check($sformatf("loop_done_c%0d", c), 32'(fbus.done), 32'h0);
        end
        fbus.loop = 1'b0;
        cyc(12);
        check("loop_c32_iin",  32'(fbus.iin),  32'(prog[3]));
        check("loop_c32_done", 32'(fbus.done), 32'h0);
        cyc(1);
        check("loop_c33_done", 32'(fbus.done), 32'h1);
        check("loop_c33_iin",  32'(fbus.iin),  32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
